video_timing_gen: RTL and testbench

- Pixel-clock video timing generator that sits directly upstream of the BGW renderer and the sprite renderer.
- Produces the blanking-inclusive h_count/v_count raster position, hs/vs sync, a blank flag, and frame/line event pulses for the CPU interrupt logic.
- All outputs are registered and mutually aligned: for any cycle, hs, vs, blank and the event pulses decode the h_count/v_count values presented in that same cycle.

---
 rtl/video_timing_gen_if.sv | 23 ++
 rtl/video_timing_gen.sv | 122 ++++++++++++
 tb/tb_video_timing_gen.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Raster-timing bundle between video_timing_gen (master) and its consumers (slave).
// line_cmp flows from the consumer into the generator; everything else flows out.
interface video_timing_gen_if;
  logic [11:0] h_count;
  logic [11:0] v_count;
  logic        hs;
  logic        vs;
  logic        blank;
  logic        frame_irq;
  logic [15:0] frame_count;
  logic [11:0] line_cmp;
  logic        line_irq;

  modport master (
    output h_count, v_count, hs, vs, blank, frame_irq, frame_count, line_irq,
    input  line_cmp
  );

  modport slave (
    input  h_count, v_count, hs, vs, blank, frame_irq, frame_count, line_irq,
    output line_cmp
  );
endinterface

// File: rtl/video_timing_gen.sv
// Free-running pixel-clock raster timing generator with aligned sync/blank/event outputs.
// Optional raster-compare interrupt is built only when VTG_LINE_IRQ_EN is defined.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic               clkPixel,
  input  logic               reset,
  video_timing_gen_if.master vtg
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HA0     = H_SYNC + H_BP;
  localparam int VA0     = V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
  localparam logic [11:0] HA_START   = 12'(HA0);
  localparam logic [11:0] HA_END     = 12'(HA0 + H_ACTIVE);
  localparam logic [11:0] VA_START   = 12'(VA0);
  localparam logic [11:0] VA_END     = 12'(VA0 + V_ACTIVE);
  localparam logic [11:0] FRAME_LINE = 12'(VA0 + V_ACTIVE);
  localparam logic        HS_ON      = (H_POL != 0);
  localparam logic        VS_ON      = (V_POL != 0);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [11:0] h_nxt;
  logic [11:0] v_nxt;
  logic        h_wrap;
  logic        frame_hit;
  logic        hs_q;
  logic        vs_q;
  logic        blank_q;
  logic        frame_irq_q;
  logic [15:0] frame_cnt;

  // Decodes use the next-count values so the registered flags line up with the counts.
  always_comb begin
    h_wrap    = (h_cnt == H_LAST);
    h_nxt     = h_wrap ? 12'd0 : h_cnt + 12'd1;
    v_nxt     = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end
    frame_hit = (h_nxt == 12'd0) && (v_nxt == FRAME_LINE);
  end

  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      hs_q        <= ~HS_ON;
      vs_q        <= ~VS_ON;
      blank_q     <= 1'b1;
      frame_irq_q <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      hs_q        <= (h_nxt < H_SYNC_END) ? HS_ON : ~HS_ON;
      vs_q        <= (v_nxt < V_SYNC_END) ? VS_ON : ~VS_ON;
      blank_q     <= !((h_nxt >= HA_START) && (h_nxt < HA_END) &&
                       (v_nxt >= VA_START) && (v_nxt < VA_END));
      frame_irq_q <= frame_hit;
    end
  end

  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      frame_cnt <= 16'd0;
    end else if (frame_hit) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign vtg.h_count     = h_cnt;
  assign vtg.v_count     = v_cnt;
  assign vtg.hs          = hs_q;
  assign vtg.vs          = vs_q;
  assign vtg.blank       = blank_q;
  assign vtg.frame_irq   = frame_irq_q;
  assign vtg.frame_count = frame_cnt;

`ifdef VTG_LINE_IRQ_EN
  logic [11:0] shadow;
  logic [11:0] shadow_nxt;
  logic        line_irq_q;

  // Compare line is latched at end of line, so a mid-line write only affects later lines.
  always_comb begin
    shadow_nxt = h_wrap ? vtg.line_cmp : shadow;
  end

  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      shadow     <= 12'hFFF;
      line_irq_q <= 1'b0;
    end else begin
      shadow     <= shadow_nxt;
      line_irq_q <= (h_nxt == 12'd0) && (v_nxt == shadow_nxt);
    end
  end

  assign vtg.line_irq = line_irq_q;
`else
  logic unused_line_cmp;
  assign unused_line_cmp = ^vtg.line_cmp;
  assign vtg.line_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a shrunken raster (32x21) so whole frames stay short.
// Raster-compare checks are compiled in when VTG_LINE_IRQ_EN is defined.
module tb_video_timing_gen;

  // 32 pixels: sync 0..5, bp 6..11, active 12..27, fp 28..31
  // 21 lines:  sync 0..1, bp 2..5,  active 6..17,  fp 18..20 (frame event on line 18)
  logic clkPixel = 1'b0;
  logic reset;

  video_timing_gen_if vif ();

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(3), .V_SYNC(2), .V_BP(4),
    .H_POL(0), .V_POL(1)
  ) dut (
    .clkPixel(clkPixel),
    .reset(reset),
    .vtg(vif)
  );

  always #5 clkPixel = ~clkPixel;

  typedef struct {
    int   n;
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic blank;
    logic firq;
  } vec_t;

  vec_t vecs[$];
  int   assert_count = 0;
  int   fail_count   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic [11:0] cmp);
    reset        = rst_v;
    vif.line_cmp = cmp;
  endtask

  task automatic tick();
    @(posedge clkPixel);
    @(negedge clkPixel);
  endtask

  task automatic waitLineIrq(input int max_ticks, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max_ticks && !seen; k++) begin
      tick();
      if (vif.line_irq) seen = 1'b1;
    end
  endtask

  initial begin
    int  cycle;
    int  pulses;
    int  lcount;
    bit  seen;

    // {cycle after release, h, v, hs, vs, blank, frame_irq}; hs active-low, vs active-high
    vecs.push_back('{1,   0,  0, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{6,   5,  0, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{7,   6,  0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{32,  31, 0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{33,  0,  1, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{65,  0,  2, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{173, 12, 5, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{204, 11, 6, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{205, 12, 6, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{220, 27, 6, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{221, 28, 6, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{565, 20, 17, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{577, 0,  18, 1'b0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{578, 1,  18, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{597, 20, 18, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{672, 31, 20, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{673, 0,  0, 1'b0, 1'b1, 1'b1, 1'b0});

    applyStimulus(1'b1, 12'd0);
    repeat (2) @(negedge clkPixel);
    checkOutput("rst_h",     32'(vif.h_count), 32'd31);
    checkOutput("rst_v",     32'(vif.v_count), 32'd20);
    checkOutput("rst_hs",    32'(vif.hs), 32'd1);
    checkOutput("rst_vs",    32'(vif.vs), 32'd0);
    checkOutput("rst_blank", 32'(vif.blank), 32'd1);
    checkOutput("rst_firq",  32'(vif.frame_irq), 32'd0);
    checkOutput("rst_fc",    32'(vif.frame_count), 32'd0);
    checkOutput("rst_lirq",  32'(vif.line_irq), 32'd0);

    applyStimulus(1'b0, 12'hFFF);
    cycle = 0;
    foreach (vecs[i]) begin
      while (cycle < vecs[i].n) begin
        tick();
        cycle++;
      end
      checkOutput($sformatf("vec%0d_h", i),     32'(vif.h_count), 32'(vecs[i].h));
      checkOutput($sformatf("vec%0d_v", i),     32'(vif.v_count), 32'(vecs[i].v));
      checkOutput($sformatf("vec%0d_hs", i),    32'(vif.hs), 32'(vecs[i].hs));
      checkOutput($sformatf("vec%0d_vs", i),    32'(vif.vs), 32'(vecs[i].vs));
      checkOutput($sformatf("vec%0d_blank", i), 32'(vif.blank), 32'(vecs[i].blank));
      checkOutput($sformatf("vec%0d_firq", i),  32'(vif.frame_irq), 32'(vecs[i].firq));
    end
    checkOutput("fc_after_frame1", 32'(vif.frame_count), 32'd1);

    // Asynchronous reset in the middle of a frame, away from any clock edge
    repeat (300) tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_h",     32'(vif.h_count), 32'd31);
    checkOutput("midrst_v",     32'(vif.v_count), 32'd20);
    checkOutput("midrst_hs",    32'(vif.hs), 32'd1);
    checkOutput("midrst_vs",    32'(vif.vs), 32'd0);
    checkOutput("midrst_blank", 32'(vif.blank), 32'd1);
    checkOutput("midrst_fc",    32'(vif.frame_count), 32'd0);
    @(negedge clkPixel);
    reset = 1'b0;
    tick();
    checkOutput("post_h",  32'(vif.h_count), 32'd0);
    checkOutput("post_v",  32'(vif.v_count), 32'd0);
    checkOutput("post_hs", 32'(vif.hs), 32'd0);
    checkOutput("post_vs", 32'(vif.vs), 32'd1);

    pulses = 0;
    for (int k = 0; k < 2 * 672; k++) begin
      tick();
      if (vif.frame_irq) begin
        pulses++;
        checkOutput($sformatf("firq%0d_h", pulses),  32'(vif.h_count), 32'd0);
        checkOutput($sformatf("firq%0d_v", pulses),  32'(vif.v_count), 32'd18);
        checkOutput($sformatf("firq%0d_fc", pulses), 32'(vif.frame_count), 32'(pulses));
      end
    end
    checkOutput("firq_pulse_count", 32'(pulses), 32'd2);

    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    checkOutput("fc_preload", 32'(vif.frame_count), 32'hFFFF);
    seen = 1'b0;
    for (int k = 0; k < 700 && !seen; k++) begin
      tick();
      if (vif.frame_irq) seen = 1'b1;
    end
    checkOutput("fc_wrap_seen", 32'(seen), 32'd1);
    checkOutput("fc_wrap",      32'(vif.frame_count), 32'd0);

`ifdef VTG_LINE_IRQ_EN
    applyStimulus(1'b1, 12'd10);
    @(negedge clkPixel);
    applyStimulus(1'b0, 12'd10);
    waitLineIrq(700, seen);
    checkOutput("lirq10_seen", 32'(seen), 32'd1);
    checkOutput("lirq10_h",    32'(vif.h_count), 32'd0);
    checkOutput("lirq10_v",    32'(vif.v_count), 32'd10);
    checkOutput("lirq10_firq", 32'(vif.frame_irq), 32'd0);
    tick();
    checkOutput("lirq10_single", 32'(vif.line_irq), 32'd0);

    repeat (15) tick();
    applyStimulus(1'b0, 12'd11);
    waitLineIrq(100, seen);
    checkOutput("lirq11_seen", 32'(seen), 32'd1);
    checkOutput("lirq11_h",    32'(vif.h_count), 32'd0);
    checkOutput("lirq11_v",    32'(vif.v_count), 32'd11);

    applyStimulus(1'b0, 12'd18);
    waitLineIrq(700, seen);
    checkOutput("lirq18_seen", 32'(seen), 32'd1);
    checkOutput("lirq18_v",    32'(vif.v_count), 32'd18);
    checkOutput("lirq18_firq", 32'(vif.frame_irq), 32'd1);

    applyStimulus(1'b0, 12'd25);
    lcount = 0;
    for (int k = 0; k < 2 * 672; k++) begin
      tick();
      if (vif.line_irq) lcount++;
    end
    checkOutput("lirq_out_of_range", 32'(lcount), 32'd0);
`else
    applyStimulus(1'b0, 12'd18);
    lcount = 0;
    for (int k = 0; k < 700; k++) begin
      tick();
      if (vif.line_irq) lcount++;
    end
    checkOutput("lirq_tied_off", 32'(lcount), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
